// File: rtl/oc_bank_arbiter_if.sv
// rtl/oc_bank_arbiter_if.sv - request, writeback, register-file and operand-collector signals of the bank arbiter
// master drives requests, writeback and RF read data; slave is the arbiter.
interface oc_bank_arbiter_if #(
  parameter int DATA_W = 256
);
  logic                  Req1_Valid;
  logic [1:0]            Req1_Bank;
  logic [2:0]            Req1_Row;
  logic [2:0]            Req1_OCID;
  logic                  Req2_Valid;
  logic [1:0]            Req2_Bank;
  logic [2:0]            Req2_Row;
  logic [2:0]            Req2_OCID;
  logic                  Req_Ready;
  logic                  WriteValid;
  logic [1:0]            WriteBank;
  logic [3:0]            RF_RdEn;
  logic [11:0]           RF_RdRow;
  logic [4*DATA_W-1:0]   RF_RdData;
  logic [3:0]            OC_Valid;
  logic [11:0]           OC_OCID;
  logic [4*DATA_W-1:0]   OC_Data;
  logic                  Busy;

  modport master (
    output Req1_Valid, Req1_Bank, Req1_Row, Req1_OCID,
    output Req2_Valid, Req2_Bank, Req2_Row, Req2_OCID,
    output WriteValid, WriteBank, RF_RdData,
    input  Req_Ready, RF_RdEn, RF_RdRow, OC_Valid, OC_OCID, OC_Data, Busy
  );

  modport slave (
    input  Req1_Valid, Req1_Bank, Req1_Row, Req1_OCID,
    input  Req2_Valid, Req2_Bank, Req2_Row, Req2_OCID,
    input  WriteValid, WriteBank, RF_RdData,
    output Req_Ready, RF_RdEn, RF_RdRow, OC_Valid, OC_OCID, OC_Data, Busy
  );
endinterface

// File: rtl/oc_bank_arbiter.sv
// rtl/oc_bank_arbiter.sv - four-bank register-file read arbiter with per-bank request FIFOs
// Two requests in per cycle, one read per bank per cycle, CDB writes win the bank.
module oc_bank_arbiter #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 256
) (
  input logic              clk,
  input logic              rst,
  oc_bank_arbiter_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef logic [PW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;

  ptr_t       wptr_q [4];
  ptr_t       wptr_d [4];
  ptr_t       rptr_q [4];
  ptr_t       rptr_d [4];
  ptr_t       waddr2 [4];
  cnt_t       cnt_q  [4];
  cnt_t       cnt_d  [4];
  logic [2:0] row_mem [4][DEPTH];
  logic [2:0] tag_mem [4][DEPTH];
  logic [3:0] fl_v_q;
  logic [3:0] fl_v_d;
  logic [2:0] fl_tag_q [4];
  logic [2:0] fl_tag_d [4];
  logic [3:0] push1;
  logic [3:0] push2;
  logic [3:0] pop;
  logic       ready;
  logic       any_queued;
  logic [3:0]  rd_en;
  logic [11:0] rd_row;
  logic [11:0] oc_ocid;
  logic [4*DATA_W-1:0] oc_data;

  // Room for two more in every bank, so a same-bank pair can always be taken.
  always_comb begin
    ready      = 1'b1;
    any_queued = 1'b0;
    for (int b = 0; b < 4; b++) begin
      if (cnt_q[b] > cnt_t'(DEPTH - 2)) ready = 1'b0;
      if (cnt_q[b] != '0) any_queued = 1'b1;
    end
  end

  always_comb begin
    rd_en  = '0;
    rd_row = '0;
    for (int b = 0; b < 4; b++) begin
      push1[b]    = bus.Req1_Valid && ready && (bus.Req1_Bank == 2'(b));
      push2[b]    = bus.Req2_Valid && ready && (bus.Req2_Bank == 2'(b));
      pop[b]      = (cnt_q[b] != '0) && !(bus.WriteValid && (bus.WriteBank == 2'(b)));
      waddr2[b]   = push1[b] ? wptr_q[b] + ptr_t'(1) : wptr_q[b];
      wptr_d[b]   = wptr_q[b] + ptr_t'(push1[b]) + ptr_t'(push2[b]);
      rptr_d[b]   = rptr_q[b] + ptr_t'(pop[b]);
      cnt_d[b]    = cnt_q[b] + cnt_t'(push1[b]) + cnt_t'(push2[b]) - cnt_t'(pop[b]);
      fl_v_d[b]   = pop[b];
      fl_tag_d[b] = pop[b] ? tag_mem[b][rptr_q[b]] : fl_tag_q[b];
      if (pop[b]) begin
        rd_en[b]         = 1'b1;
        rd_row[3*b +: 3] = row_mem[b][rptr_q[b]];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fl_v_q <= '0;
      for (int b = 0; b < 4; b++) begin
        wptr_q[b]   <= '0;
        rptr_q[b]   <= '0;
        cnt_q[b]    <= '0;
        fl_tag_q[b] <= '0;
      end
    end else begin
      fl_v_q <= fl_v_d;
      for (int b = 0; b < 4; b++) begin
        wptr_q[b]   <= wptr_d[b];
        rptr_q[b]   <= rptr_d[b];
        cnt_q[b]    <= cnt_d[b];
        fl_tag_q[b] <= fl_tag_d[b];
      end
    end
  end

  // Entry storage is qualified by the counts, so it needs no reset.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (push1[b]) begin
        row_mem[b][wptr_q[b]] <= bus.Req1_Row;
        tag_mem[b][wptr_q[b]] <= bus.Req1_OCID;
      end
      if (push2[b]) begin
        row_mem[b][waddr2[b]] <= bus.Req2_Row;
        tag_mem[b][waddr2[b]] <= bus.Req2_OCID;
      end
    end
  end

  always_comb begin
    oc_ocid = '0;
    for (int b = 0; b < 4; b++) begin
      if (fl_v_q[b]) oc_ocid[3*b +: 3] = fl_tag_q[b];
    end
  end

  assign oc_data       = bus.RF_RdData;
  assign bus.Req_Ready = ready;
  assign bus.RF_RdEn   = rd_en;
  assign bus.RF_RdRow  = rd_row;
  assign bus.OC_Valid  = fl_v_q;
  assign bus.OC_OCID   = oc_ocid;
  assign bus.OC_Data   = oc_data;
  assign bus.Busy      = any_queued || (fl_v_q != '0);
endmodule

// File: doc/oc_bank_arbiter.md
# oc_bank_arbiter

Register-file read arbiter sitting directly downstream of the register mapping unit and upstream of the operand collectors. Each cycle it accepts up to two physical read requests (bank, row, OCID tag), queues them in per-bank FIFOs, and issues at most one read per bank per cycle to the four register-file banks. CDB writeback takes priority over reads on the same bank. Returned bank data is forwarded, tagged with its OCID, to the operand collectors one cycle after issue.

## Interface
- DEPTH, 4, entries per bank FIFO; power of two, ≥2
- DATA_W, 256, bank read width (8 lanes × 32 bit)
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- Req1_Valid  in  1  src1 request valid
- Req1_Bank  in  2  src1 physical bank
- Req1_Row  in  3  src1 physical row
- Req1_OCID  in  3  src1 tag {OC index, slot}
- Req2_Valid / Req2_Bank / Req2_Row / Req2_OCID  in  1/2/3/3  src2 request, same meaning
- Req_Ready  out  1  both requests may be presented this cycle
- WriteValid  in  1  CDB write to RF this cycle
- WriteBank  in  2  bank being written
- RF_RdEn  out  4  per-bank read enable
- RF_RdRow  out  12  per-bank row, bank b at [3b+2:3b]
- RF_RdData  in  4×DATA_W  per-bank read data, valid the cycle after RF_RdEn
- OC_Valid  out  4  per-bank operand delivery valid
- OC_OCID  out  12  per-bank destination tag, bank b at [3b+2:3b]
- OC_Data  out  4×DATA_W  per-bank operand data
- Busy  out  1  any FIFO non-empty or any read in flight

## Operation
- Per bank b: circular FIFO of {row, OCID}, read/write pointers of log2(DEPTH) bits wrapping modulo DEPTH, occupancy count 0..DEPTH.
- Req_Ready = 1 iff every bank has ≥2 free slots. Derived from counts only, never from request inputs.
- Enqueue: ReqN is accepted when ReqN_Valid & Req_Ready. If both target the same bank, Req1 is written first and Req2 second (count +2). If Req_Ready=0, valid requests are ignored; the upstream stage holds them.
- Issue per bank, every cycle: if count>0 and !(WriteValid & WriteBank==b):
  - RF_RdEn[b]=1 and RF_RdRow[b]=head row.
  - Head is popped at the clock edge; head OCID is captured into a per-bank in-flight register.
- Otherwise RF_RdEn[b]=0 and RF_RdRow[b]=0.
- Enqueue and pop on the same bank in the same cycle are both performed; count changes by (pushes − 1).
- Delivery: the cycle after bank b issues, OC_Valid[b]=1, OC_OCID[b]=captured tag, and OC_Data[b]=RF_RdData[b] (combinational pass-through). Otherwise OC_Valid[b]=0 and OC_OCID[b]=0. OC_Data is don't-care when invalid.
- Banks are fully independent. Per-bank order is strict FIFO. There is no ordering across banks.
- Busy = OR of (count_b≠0) and in-flight valid bits.

## Timing
- Reset (async, rst=0): all FIFOs empty, pointers/counts 0, in-flight valids 0. Outputs: RF_RdEn=0, RF_RdRow=0, OC_Valid=0, OC_OCID=0, Busy=0, Req_Ready=1. Reset asserted mid-operation discards all queued and in-flight requests immediately; no delivery follows.
- Latency, no conflicts:
  - Request accepted at edge of cycle t.
  - RF_RdEn in cycle t+1.
  - OC_Valid in cycle t+2.
- Same-bank pair: second read issues in t+2, delivered in t+3.
- Each cycle of WriteValid on bank b delays that bank's head by one cycle. Other banks are unaffected.
- Full boundary: count=DEPTH−1 or DEPTH forces Req_Ready=0. Issue continues regardless. Req_Ready returns to 1 the cycle after every count ≤ DEPTH−2.
- Sustained throughput: 4 reads/cycle across banks, 1 read/cycle per bank.

## Test plan
- Reset: drive rst=0 mid-stream with 3 entries queued in bank 1 -> all outputs 0 immediately, Req_Ready=1. After release, no OC_Valid appears.
- Disjoint banks: Req1 (bank0, row2, OCID0) + Req2 (bank1, row5, OCID1) at cycle t -> at t+1, RF_RdEn=0011 with rows 2/5. At t+2, OC_Valid=0011, OC_OCID 0/1, data equal to the RF_RdData slices.
- Bank conflict: Req1 (bank2, row1, OCID4) + Req2 (bank2, row3, OCID5) -> reads of row1 then row3 in t+1, t+2. Deliveries of OCID4 then OCID5 in t+2, t+3.
- Write priority: queue bank3 row6 and hold WriteValid, WriteBank=3 for 2 cycles -> RF_RdEn[3]=0 for those cycles, read issued in the third cycle. Bank0 traffic is unaffected.
- Full/wrap: hold WriteValid on bank3 and push two same-bank pairs (count 4) -> Req_Ready=0. Release the write -> four reads in push order, Req_Ready=1 once count ≤2. Repeat three times to exercise pointer wrap.
- Busy: single request -> Busy high from t+1 through t+2, low at t+3.
